adder_sub_8bit: RTL and testbench
=================================

# adder_sub_8bit

Registered 8-bit two's-complement adder/subtractor with carry-out and signed-overflow flags. It is the arithmetic primitive for the parking-system counters, such as occupancy and free-slot arithmetic. A single select line chooses A+B or A−B. Results are captured in output registers on the clock edge, so downstream logic sees stable, glitch-free values.

## Interface
- No parameters. Width is fixed at 8 bits.
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset; clears all output registers
- A  input  8  first operand (minuend when subtracting)
- B  input  8  second operand (subtrahend when subtracting)
- sel  input  1  operation select: 0 = add (A+B), 1 = subtract (A−B)
- Z  output  8  registered result, modulo 2^8
- Cout  output  1  registered carry-out of bit 7 of the internal adder
- V  output  1  registered signed-overflow flag

## Operation
- Datapath: one 8-bit ripple-carry adder built from eight full-adder cells. Operand B is conditioned as B_eff = B XOR {8{sel}}. Carry-in c0 = sel.
  - Add: Z = A + B.
  - Subtract: Z = A + ~B + 1.
- Cout = carry out of cell 7, for both operations.
  - Add: Cout = 1 when the unsigned sum is ≥ 256.
  - Subtract: Cout = 1 when A ≥ B unsigned (no borrow). Cout = 0 when a borrow occurs.
- V = c7 XOR c8, where c7 is the carry into bit 7 and c8 = Cout.
  - Add: V = 1 when two operands of the same sign give a result of the opposite sign.
  - Subtract: V = 1 when operands of different sign give a result whose sign differs from A.
- All three results (Z, Cout, V) are computed combinationally and registered together. They always belong to the same operand set.
- Subtract with B = 0x00 gives Z = A and Cout = 1 (no borrow).
- Add with B = 0x00 gives Z = A and Cout = 0.
- Wrap-around is silent: results are modulo 256 with no saturation. Flags report the condition.

## Timing
- Latency: exactly 1 clock. Inputs A, B, sel are sampled at rising edge N. Z, Cout, V reflect them after edge N and hold until edge N+1.
- Throughput: one operation per clock. There is no handshake and no valid signal; a new operand set is accepted every cycle.
- Reset values: Z = 0x00, Cout = 0, V = 0.
- Reset behaviour:
  - Reset takes effect immediately on rst rising, independent of clk.
  - While rst is high, outputs stay at their reset values and input edges are ignored.
  - The first edge after rst deasserts captures the inputs present at that edge.
- Reset mid-operation discards the pending result. No partial results are retained.
- Inputs must meet setup and hold timing at clk. Changing sel alone between edges affects only the next captured result.

## Test plan
- Basic add/sub:
  - A=0x01, B=0x02, sel=0 → Z=0x03, Cout=0, V=0.
  - Same operands, sel=1 → Z=0xFF, Cout=0, V=0.
- No-borrow subtract:
  - A=0x06, B=0x04, sel=0 → Z=0x0A, Cout=0.
  - Same operands, sel=1 → Z=0x02, Cout=1.
- Mixed operands:
  - A=0x0F, B=0x02, sel=0 → Z=0x11, Cout=0.
  - Same operands, sel=1 → Z=0x0D, Cout=1.
  - A=0x0A, B=0x0C, sel=1 → Z=0xFE, Cout=0.
  - A=0x0F, B=0x0E, sel=1 → Z=0x01, Cout=1.
- Overflow and wrap:
  - 0x7F+0x01 → Z=0x80, V=1, Cout=0.
  - 0x80−0x01 → Z=0x7F, V=1, Cout=1.
  - 0xFF+0x01 → Z=0x00, Cout=1, V=0.
  - 0x05−0x00 → Z=0x05, Cout=1.
- Latency: change operands every cycle → each result appears exactly one edge after its operands. Check back-to-back alternating sel.
- Reset: assert rst asynchronously between edges while Z=0x0A → Z, Cout, V go to 0 immediately and stay there while rst is high. The first post-release edge captures the current inputs.

Source files
------------

// File: rtl/adder_sub_8bit.sv
// Registered 8-bit two's-complement adder/subtractor with carry-out and
// signed-overflow flags. One select line chooses A+B (sel=0) or A-B (sel=1);
// Z, Cout and V are captured together one clock after their operands.
module adder_sub_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       sel,
    output logic [7:0] Z,
    output logic       Cout,
    output logic       V
);

    localparam int unsigned W = 8;

    logic [W-1:0] z_d;
    logic [W-1:0] z_q;
    logic         cout_d;
    logic         cout_q;
    logic         v_d;
    logic         v_q;

    // Ripple-carry chain of full-adder cells; subtract inverts B and injects carry-in.
    always_comb begin : p_datapath
        logic [W:0]   carry;
        logic [W-1:0] b_eff;
        logic [W-1:0] sum;

        carry    = '0;
        sum      = '0;
        b_eff    = B ^ {W{sel}};
        carry[0] = sel;
        for (int i = 0; i < int'(W); i++) begin
            sum[i]     = A[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
        end

        z_d    = sum;
        cout_d = carry[W];
        // Overflow when the carry into the sign bit differs from the carry out of it.
        v_d    = carry[W-1] ^ carry[W];
    end

    // Output registers; result and both flags always refer to the same operand set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q    <= '0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            z_q    <= z_d;
            cout_q <= cout_d;
            v_q    <= v_d;
        end
    end

    assign Z    = z_q;
    assign Cout = cout_q;
    assign V    = v_q;

endmodule

// File: tb/tb_adder_sub_8bit.sv
// Scoreboard bench for adder_sub_8bit: the stimulus process pushes the
// hand-computed response for every captured operand set, and a monitor on the
// falling edge pops and compares against the registered outputs.
module tb_adder_sub_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       sel;
    logic [7:0] Z;
    logic       Cout;
    logic       V;

    adder_sub_8bit dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .sel  (sel),
        .Z    (Z),
        .Cout (Cout),
        .V    (V)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  z;
        logic        c;
        logic        v;
        logic [15:0] id;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_id   = 0;

    // Single comparison point shared by the monitor and the reset checks.
    task automatic check(input string nm, input int id, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (vec %0d): got %h expected %h", nm, id, got, exp);
    endtask

    // Called at a falling edge: present operands, and once the rising edge
    // captures them, queue the expected response; returns at the next falling edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] z, input logic c, input logic v);
        exp_t e;
        A   = a;
        B   = b;
        sel = s;
        @(posedge clk);
        e.z  = z;
        e.c  = c;
        e.v  = v;
        e.id = 16'(vec_id);
        sb_q.push_back(e);
        vec_id++;
        @(negedge clk);
    endtask

    // Monitor: outputs are stable at the falling edge after each capture.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("Z",    int'(e.id), Z,        e.z);
            check("Cout", int'(e.id), 8'(Cout), 8'(e.c));
            check("V",    int'(e.id), 8'(V),    8'(e.v));
        end
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        A   = 8'h7F;
        B   = 8'h01;
        sel = 1'b0;

        // Reset state, including across clock edges with live operands.
        #2;
        check("reset_Z",    -1, Z,        8'h00);
        check("reset_Cout", -1, 8'(Cout), 8'h00);
        check("reset_V",    -1, 8'(V),    8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold_Z", -1, Z,     8'h00);
        check("reset_hold_V", -1, 8'(V), 8'h00);

        @(negedge clk);
        rst = 1'b0;

        // Basic, borrow and no-borrow, mixed operands.
        drive(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        drive(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);
        drive(8'h06, 8'h04, 1'b0, 8'h0A, 1'b0, 1'b0);
        drive(8'h06, 8'h04, 1'b1, 8'h02, 1'b1, 1'b0);
        drive(8'h0F, 8'h02, 1'b0, 8'h11, 1'b0, 1'b0);
        drive(8'h0F, 8'h02, 1'b1, 8'h0D, 1'b1, 1'b0);
        drive(8'h0A, 8'h0C, 1'b1, 8'hFE, 1'b0, 1'b0);
        drive(8'h0F, 8'h0E, 1'b1, 8'h01, 1'b1, 1'b0);
        // Overflow, wrap and zero-operand corners.
        drive(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        drive(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        drive(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        drive(8'h05, 8'h00, 1'b1, 8'h05, 1'b1, 1'b0);
        drive(8'h05, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0);
        drive(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        drive(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1);
        drive(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
        drive(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
        drive(8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0);
        // Back-to-back alternating select.
        drive(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        drive(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        drive(8'h30, 8'h05, 1'b0, 8'h35, 1'b0, 1'b0);
        drive(8'h30, 8'h05, 1'b1, 8'h2B, 1'b1, 1'b0);

        // Asynchronous reset between edges while Z holds 0x0A.
        drive(8'h06, 8'h04, 1'b0, 8'h0A, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        A   = 8'h7F;
        B   = 8'h01;
        sel = 1'b0;
        #1;
        check("async_rst_Z",    -1, Z,        8'h00);
        check("async_rst_Cout", -1, 8'(Cout), 8'h00);
        check("async_rst_V",    -1, 8'(V),    8'h00);
        @(posedge clk);
        #1;
        check("rst_held_Z", -1, Z,     8'h00);
        check("rst_held_V", -1, 8'(V), 8'h00);
        @(negedge clk);
        rst = 1'b0;
        // First edge after release captures the operands present then.
        drive(8'h0F, 8'h0E, 1'b1, 8'h01, 1'b1, 1'b0);
        drive(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
